// File: rtl/ahb_lite_dma_initiator.sv
// Command-driven AHB-Lite master: one single transfer outstanding at a time,
// no bursts, no locking. Read data, error and timeout status are returned on
// a valid/ready response channel.
module ahb_lite_dma_initiator #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TO_W    = 16
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic        cmd_write,
  input  logic [63:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic [31:0] haddr,
  output logic [2:0]  hburst,
  output logic        hmastlock,
  output logic [3:0]  hprot,
  output logic [2:0]  hsize,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [63:0] hwdata,
  input  logic [63:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? TIMEOUT - 1 : 0);

  state_t            state_q;
  state_t            state_d;

  logic [31:0]       addr_q;
  logic [2:0]        size_q;
  logic              write_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;
  logic              err_q;
  logic              to_q;
  logic [TO_W-1:0]   tcnt_q;

  logic              misaligned;
  logic              cmd_accept;
  logic              data_done;
  logic              to_hit;
  logic              tcnt_inc;
  logic              rsp_done;

  // Alignment check of the incoming command against its transfer size.
  always_comb begin
    misaligned = 1'b0;
    case (cmd_size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = cmd_addr[0];
      3'd2:    misaligned = |cmd_addr[1:0];
      3'd3:    misaligned = |cmd_addr[2:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Next-state decode; a stall reaching the timeout limit aborts straight to RESP.
  always_comb begin
    state_d    = state_q;
    cmd_accept = 1'b0;
    data_done  = 1'b0;
    to_hit     = 1'b0;
    tcnt_inc   = 1'b0;
    rsp_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_accept = 1'b1;
          state_d    = misaligned ? ST_RESP : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (hready) begin
          state_d = ST_DATA;
        end else if (TO_EN && (tcnt_q == TO_LAST)) begin
          to_hit  = 1'b1;
          state_d = ST_RESP;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      ST_DATA: begin
        if (hready) begin
          data_done = 1'b1;
          state_d   = ST_RESP;
        end else if (TO_EN && (tcnt_q == TO_LAST)) begin
          to_hit  = 1'b1;
          state_d = ST_RESP;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Consecutive-stall counter, restarted by a new transfer or any ready cycle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l)                            tcnt_q <= '0;
    else if (cmd_accept || hready || to_hit) tcnt_q <= '0;
    else if (tcnt_inc)                       tcnt_q <= tcnt_q + 1'b1;
  end

  // Command capture and response capture; response fields clear once consumed.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      if (cmd_accept) begin
        addr_q  <= cmd_addr;
        size_q  <= cmd_size;
        write_q <= cmd_write;
        wdata_q <= cmd_wdata;
        if (misaligned) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
          to_q    <= 1'b0;
        end
      end
      if (data_done) begin
        rdata_q <= (!write_q && !hresp) ? hrdata : '0;
        err_q   <= hresp;
        to_q    <= 1'b0;
      end
      if (to_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
        to_q    <= 1'b1;
      end
      if (rsp_done) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
        to_q    <= 1'b0;
      end
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;

  assign haddr     = addr_q;
  assign hsize     = size_q;
  assign hwrite    = write_q;
  assign hwdata    = wdata_q;
  assign htrans    = (state_q == ST_ADDR) ? 2'b10 : 2'b00;
  assign hburst    = 3'b000;
  assign hmastlock = 1'b0;
  assign hprot     = 4'b0011;

endmodule

// File: tb/tb_ahb_lite_dma_initiator.sv
// Bench for ahb_lite_dma_initiator: a configurable AHB slave/monitor plus
// feature tasks that queue expected responses and compare them on arrival.
module tb_ahb_lite_dma_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_l;
  logic        cmd_valid;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic        cmd_write;
  logic [63:0] cmd_wdata;
  logic        rsp_ready;
  logic [63:0] hrdata = '0;
  logic        hready = 1'b1;
  logic        hresp  = 1'b0;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, hmastlock, hwrite;
  logic [63:0] rsp_rdata, hwdata;
  logic [31:0] haddr;
  logic [2:0]  hburst, hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  logic        n_cmd_ready, n_rsp_valid, n_rsp_err, n_rsp_timeout, n_busy, n_hmastlock, n_hwrite;
  logic [63:0] n_rsp_rdata, n_hwdata;
  logic [31:0] n_haddr;
  logic [2:0]  n_hburst, n_hsize;
  logic [3:0]  n_hprot;
  logic [1:0]  n_htrans;

  ahb_lite_dma_initiator #(.TIMEOUT(8), .TO_W(16)) dut (
    .clk(clk), .reset_l(reset_l),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .haddr(haddr), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .hsize(hsize),
    .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp)
  );

  // Second instance with the timeout disabled, fed the same inputs.
  ahb_lite_dma_initiator #(.TIMEOUT(0), .TO_W(16)) dut_nto (
    .clk(clk), .reset_l(reset_l),
    .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready), .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(n_rsp_rdata), .rsp_err(n_rsp_err),
    .rsp_timeout(n_rsp_timeout), .busy(n_busy),
    .haddr(n_haddr), .hburst(n_hburst), .hmastlock(n_hmastlock), .hprot(n_hprot), .hsize(n_hsize),
    .htrans(n_htrans), .hwrite(n_hwrite), .hwdata(n_hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp)
  );

  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  int tests_run    = 0;
  int tests_failed = 0;

  // Slave behaviour knobs (written by the main thread only).
  int aw_cfg    = 0;
  int dw_cfg    = 0;
  bit err_cfg   = 1'b0;
  bit stall_all = 1'b0;

  // Slave/monitor state (written by the slave process only).
  logic [63:0] mem [logic [31:0]];
  bit          s_dphase = 1'b0;
  int          acnt = 0, dcnt = 0;
  logic [31:0] s_addr = '0;
  bit          s_write = 1'b0;
  int          nonseq_cnt = 0, addr_unstable = 0, wdata_unstable = 0;
  int          dphase_not_idle = 0, dphase_cyc = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_haddr = '0;
  logic [2:0]  prev_hsize = '0;
  logic        prev_hwrite = 1'b0;
  logic [63:0] dp_wdata = '0;
  bit          dp_first = 1'b0;
  logic [31:0] obs_haddr = '0;
  logic [2:0]  obs_hsize = '0;
  logic        obs_hwrite = 1'b0;

  // AHB slave model and bus monitor: observe the current cycle, then drive the next edge.
  always @(negedge clk) begin
    if (!reset_l) begin
      s_dphase   = 1'b0;
      acnt       = 0;
      dcnt       = 0;
      prev_stall = 1'b0;
      hready     = 1'b1;
      hresp      = 1'b0;
      hrdata     = JUNK;
    end else begin
      if (htrans == 2'b10) begin
        nonseq_cnt++;
        obs_haddr  = haddr;
        obs_hsize  = hsize;
        obs_hwrite = hwrite;
        if (prev_stall && (haddr !== prev_haddr || hsize !== prev_hsize || hwrite !== prev_hwrite))
          addr_unstable++;
      end
      if (s_dphase) begin
        dphase_cyc++;
        if (htrans !== 2'b00) dphase_not_idle++;
        if (dp_first) begin
          dp_wdata = hwdata;
          dp_first = 1'b0;
        end else if (hwdata !== dp_wdata) begin
          wdata_unstable++;
        end
      end
      hresp  = 1'b0;
      hrdata = JUNK;
      if (stall_all) begin
        hready = 1'b0;
      end else if (s_dphase) begin
        hresp = err_cfg;
        if (dcnt < dw_cfg) begin
          hready = 1'b0;
          dcnt++;
        end else begin
          hready = 1'b1;
          if (s_write) mem[s_addr] = hwdata;
          else if (!err_cfg) hrdata = mem.exists(s_addr) ? mem[s_addr] : '0;
          s_dphase = 1'b0;
        end
      end else if (htrans == 2'b10) begin
        if (acnt < aw_cfg) begin
          hready = 1'b0;
          acnt++;
        end else begin
          hready   = 1'b1;
          s_addr   = haddr;
          s_write  = hwrite;
          s_dphase = 1'b1;
          dp_first = 1'b1;
          acnt     = 0;
          dcnt     = 0;
        end
      end else begin
        hready = 1'b1;
      end
      prev_stall  = (htrans == 2'b10) && !hready;
      prev_haddr  = haddr;
      prev_hsize  = hsize;
      prev_hwrite = hwrite;
    end
  end

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic        to;
    int          lat;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [63:0] obs_rdata;
  logic        obs_err, obs_to;
  int          obs_lat;
  int          ns_base;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Issue one command and wait (bounded) for the response; records what was seen.
  task automatic issue(input logic [31:0] a, input logic [2:0] sz, input logic w,
                       input logic [63:0] wd, input int max_cyc);
    int g = 0;
    while (cmd_ready !== 1'b1 && g < 50) begin
      step();
      g++;
    end
    ns_base   = nonseq_cnt;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_size  = sz;
    cmd_write = w;
    cmd_wdata = wd;
    step();
    cmd_valid = 1'b0;
    obs_lat   = 1;
    while (rsp_valid !== 1'b1 && obs_lat < max_cyc) begin
      step();
      obs_lat++;
    end
    obs_rdata = rsp_rdata;
    obs_err   = rsp_err;
    obs_to    = rsp_timeout;
  endtask

  task automatic push_exp(input logic [63:0] rd, input logic er, input logic tmo, input int lat);
    rsp_t e;
    e.rdata = rd;
    e.err   = er;
    e.to    = tmo;
    e.lat   = lat;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    step();
    step();
    tests_run++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, htrans, hwrite, hsize, hburst, hmastlock, hprot}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b0, 4'b0011}) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b%b%b%b%b %b %b %b %b %b %b", cmd_ready, rsp_valid, rsp_err,
               rsp_timeout, busy, htrans, hwrite, hsize, hburst, hmastlock, hprot);
    end
    tests_run++;
    if ({haddr, hwdata, rsp_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got haddr=%h hwdata=%h rdata=%h want 0", haddr, hwdata, rsp_rdata);
    end
    tests_run++;
    if ({n_cmd_ready, n_rsp_valid, n_rsp_err, n_rsp_timeout, n_busy, n_htrans, n_hwrite, n_hsize,
         n_hburst, n_hmastlock, n_hprot, n_haddr, n_hwdata, n_rsp_rdata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 3'b000, 1'b0, 4'b0011, 32'h0, 64'h0, 64'h0}) begin
      tests_failed++;
      $display("FAIL reset_nto: got rdy=%b busy=%b htrans=%b hprot=%b haddr=%h", n_cmd_ready, n_busy,
               n_htrans, n_hprot, n_haddr);
    end
    reset_l = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    rsp_t e;
    push_exp(64'h0, 1'b0, 1'b0, 3);
    issue(32'hEE00_0010, 3'd2, 1'b1, 64'h0000_0000_CAFE_F00D, 20);
    e = exp_q.pop_front();
    tests_run++;
    if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat) begin
      tests_failed++;
      $display("FAIL wr_rsp: got %h/%b/%b lat %0d want %h/%b/%b lat %0d", obs_rdata, obs_err, obs_to,
               obs_lat, e.rdata, e.err, e.to, e.lat);
    end
    tests_run++;
    if (nonseq_cnt - ns_base != 1 || obs_haddr !== 32'hEE00_0010 || obs_hwrite !== 1'b1 || obs_hsize !== 3'd2) begin
      tests_failed++;
      $display("FAIL wr_addr: got nonseq=%0d haddr=%h hwrite=%b hsize=%0d want 1 ee000010 1 2",
               nonseq_cnt - ns_base, obs_haddr, obs_hwrite, obs_hsize);
    end
    step();
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_ready_c4: got cmd_ready=%b want 1", cmd_ready);
    end
    push_exp(64'h0000_0000_CAFE_F00D, 1'b0, 1'b0, 3);
    issue(32'hEE00_0010, 3'd2, 1'b0, 64'h0, 20);
    e = exp_q.pop_front();
    tests_run++;
    if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat) begin
      tests_failed++;
      $display("FAIL rd_rsp: got %h/%b/%b lat %0d want %h/%b/%b lat %0d", obs_rdata, obs_err, obs_to,
               obs_lat, e.rdata, e.err, e.to, e.lat);
    end
    tests_run++;
    if (nonseq_cnt - ns_base != 1 || obs_hwrite !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_addr: got nonseq=%0d hwrite=%b want 1 0", nonseq_cnt - ns_base, obs_hwrite);
    end
    step();
  endtask

  task automatic test_sizes();
    logic [31:0] ta [4] = '{32'hEE00_0041, 32'hEE00_0042, 32'hEE00_0044, 32'hEE00_0048};
    logic [63:0] td [4] = '{64'h0000_0000_0000_00A5, 64'h0000_0000_0000_B00C,
                            64'h0000_0000_1234_5678, 64'hFEDC_BA98_7654_3210};
    rsp_t e;
    for (int i = 0; i < 4; i++) begin
      push_exp(64'h0, 1'b0, 1'b0, 3);
      issue(ta[i], 3'(i), 1'b1, td[i], 20);
      e = exp_q.pop_front();
      tests_run++;
      if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat
          || obs_hsize !== 3'(i) || obs_haddr !== ta[i]) begin
        tests_failed++;
        $display("FAIL size_wr%0d: got %h/%b lat %0d hsize=%0d haddr=%h want err 0 lat 3 hsize=%0d haddr=%h",
                 i, obs_rdata, obs_err, obs_lat, obs_hsize, obs_haddr, i, ta[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      push_exp(td[i], 1'b0, 1'b0, 3);
      issue(ta[i], 3'(i), 1'b0, 64'h0, 20);
      e = exp_q.pop_front();
      tests_run++;
      if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat) begin
        tests_failed++;
        $display("FAIL size_rd%0d: got %h/%b/%b lat %0d want %h/%b/%b lat %0d", i, obs_rdata, obs_err,
                 obs_to, obs_lat, e.rdata, e.err, e.to, e.lat);
      end
    end
    step();
  endtask

  task automatic test_wait_states();
    rsp_t e;
    int au, wu;
    aw_cfg = 3;
    dw_cfg = 2;
    au = addr_unstable;
    wu = wdata_unstable;
    push_exp(64'h0, 1'b0, 1'b0, 8);
    issue(32'hEE00_0020, 3'd3, 1'b1, 64'h1122_3344_5566_7788, 20);
    e = exp_q.pop_front();
    tests_run++;
    if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat) begin
      tests_failed++;
      $display("FAIL ws_wr_rsp: got %h/%b/%b lat %0d want %h/%b/%b lat %0d", obs_rdata, obs_err, obs_to,
               obs_lat, e.rdata, e.err, e.to, e.lat);
    end
    tests_run++;
    if (nonseq_cnt - ns_base != 4 || addr_unstable != au || wdata_unstable != wu) begin
      tests_failed++;
      $display("FAIL ws_stable: got nonseq=%0d addr_chg=%0d wdata_chg=%0d want 4 0 0",
               nonseq_cnt - ns_base, addr_unstable - au, wdata_unstable - wu);
    end
    push_exp(64'h1122_3344_5566_7788, 1'b0, 1'b0, 8);
    issue(32'hEE00_0020, 3'd3, 1'b0, 64'h0, 20);
    e = exp_q.pop_front();
    tests_run++;
    if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat) begin
      tests_failed++;
      $display("FAIL ws_rd_rsp: got %h/%b/%b lat %0d want %h/%b/%b lat %0d", obs_rdata, obs_err, obs_to,
               obs_lat, e.rdata, e.err, e.to, e.lat);
    end
    aw_cfg = 0;
    dw_cfg = 0;
    step();
  endtask

  task automatic test_error();
    rsp_t e;
    int ni, dc;
    dw_cfg  = 1;
    err_cfg = 1'b1;
    ni = dphase_not_idle;
    dc = dphase_cyc;
    push_exp(64'h0, 1'b1, 1'b0, 4);
    issue(32'hEE00_0010, 3'd2, 1'b0, 64'h0, 20);
    e = exp_q.pop_front();
    tests_run++;
    if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat) begin
      tests_failed++;
      $display("FAIL err_rsp: got %h/%b/%b lat %0d want %h/%b/%b lat %0d", obs_rdata, obs_err, obs_to,
               obs_lat, e.rdata, e.err, e.to, e.lat);
    end
    tests_run++;
    if (dphase_cyc - dc != 2 || dphase_not_idle != ni) begin
      tests_failed++;
      $display("FAIL err_htrans: got data_cycles=%0d non_idle=%0d want 2 0", dphase_cyc - dc,
               dphase_not_idle - ni);
    end
    dw_cfg  = 0;
    err_cfg = 1'b0;
    step();
  endtask

  task automatic test_misaligned();
    logic [31:0] ma [5] = '{32'hEE00_0012, 32'hEE00_0010, 32'hEE00_0013, 32'hEE00_0004, 32'hEE00_0011};
    logic [2:0]  ms [5] = '{3'd2, 3'd4, 3'd1, 3'd3, 3'd7};
    rsp_t e;
    for (int i = 0; i < 5; i++) begin
      push_exp(64'h0, 1'b1, 1'b0, 1);
      issue(ma[i], ms[i], 1'b0, 64'h0, 20);
      e = exp_q.pop_front();
      tests_run++;
      if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat
          || nonseq_cnt != ns_base) begin
        tests_failed++;
        $display("FAIL misalign%0d: got %h/%b/%b lat %0d nonseq=%0d want %h/%b/%b lat %0d nonseq=0", i,
                 obs_rdata, obs_err, obs_to, obs_lat, nonseq_cnt - ns_base, e.rdata, e.err, e.to, e.lat);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    rsp_t e;
    int seen = 0;
    int left_ns = 0;
    stall_all = 1'b1;
    push_exp(64'h0, 1'b1, 1'b1, 9);
    issue(32'hEE00_0010, 3'd2, 1'b0, 64'h0, 20);
    e = exp_q.pop_front();
    tests_run++;
    if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat || htrans !== 2'b00) begin
      tests_failed++;
      $display("FAIL timeout_rsp: got %h/%b/%b lat %0d htrans=%b want %h/%b/%b lat %0d htrans=00",
               obs_rdata, obs_err, obs_to, obs_lat, htrans, e.rdata, e.err, e.to, e.lat);
    end
    for (int i = 0; i < 1000; i++) begin
      step();
      if (n_rsp_valid === 1'b1) seen++;
      if (n_htrans !== 2'b10) left_ns++;
    end
    tests_run++;
    if (seen != 0 || left_ns != 0 || n_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_timeout: got rsp_cycles=%0d non_nonseq=%0d busy=%b want 0 0 1", seen, left_ns, n_busy);
    end
    stall_all = 1'b0;
    reset_l   = 1'b0;
    step();
    reset_l = 1'b1;
    step();
    tests_run++;
    if (n_busy !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_reset: got busy=%b/%b want 0/0", busy, n_busy);
    end
  endtask

  task automatic test_backpressure();
    rsp_t e;
    int base;
    rsp_ready = 1'b0;
    push_exp(64'h0000_0000_CAFE_F00D, 1'b0, 1'b0, 3);
    issue(32'hEE00_0010, 3'd2, 1'b0, 64'h0, 20);
    e = exp_q.pop_front();
    tests_run++;
    if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat) begin
      tests_failed++;
      $display("FAIL bp_rsp: got %h/%b/%b lat %0d want %h/%b/%b lat %0d", obs_rdata, obs_err, obs_to,
               obs_lat, e.rdata, e.err, e.to, e.lat);
    end
    base      = nonseq_cnt;
    cmd_valid = 1'b1;
    cmd_addr  = 32'hEE00_0100;
    cmd_size  = 3'd2;
    cmd_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== 1'b0 || cmd_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got valid=%b rdata=%h err=%b cmd_ready=%b want 1 %h 0 0", i, rsp_valid,
                 rsp_rdata, rsp_err, cmd_ready, e.rdata);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    step();
    step();
    tests_run++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || nonseq_cnt != base) begin
      tests_failed++;
      $display("FAIL bp_release: got valid=%b cmd_ready=%b extra_nonseq=%0d want 0 1 0", rsp_valid,
               cmd_ready, nonseq_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    rsp_t e;
    dw_cfg    = 5;
    cmd_valid = 1'b1;
    cmd_addr  = 32'hEE00_0200;
    cmd_size  = 3'd3;
    cmd_write = 1'b1;
    cmd_wdata = 64'h5555_AAAA_5555_AAAA;
    step();
    cmd_valid = 1'b0;
    step();
    tests_run++;
    if (busy !== 1'b1 || htrans !== 2'b00 || hwdata !== 64'h5555_AAAA_5555_AAAA) begin
      tests_failed++;
      $display("FAIL mid_data: got busy=%b htrans=%b hwdata=%h want 1 00 5555aaaa5555aaaa", busy, htrans, hwdata);
    end
    reset_l = 1'b0;
    #1;
    tests_run++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, htrans, hwrite, hsize, hprot}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000, 4'b0011}) begin
      tests_failed++;
      $display("FAIL mid_reset_ctrl: got rdy=%b vld=%b err=%b to=%b busy=%b htrans=%b hwrite=%b hsize=%0d",
               cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, htrans, hwrite, hsize);
    end
    tests_run++;
    if ({haddr, hwdata, rsp_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_data: got haddr=%h hwdata=%h rdata=%h want 0", haddr, hwdata, rsp_rdata);
    end
    step();
    reset_l = 1'b1;
    dw_cfg  = 0;
    step();
    push_exp(64'h0000_0000_CAFE_F00D, 1'b0, 1'b0, 3);
    issue(32'hEE00_0010, 3'd2, 1'b0, 64'h0, 20);
    e = exp_q.pop_front();
    tests_run++;
    if ({obs_rdata, obs_err, obs_to} !== {e.rdata, e.err, e.to} || obs_lat != e.lat) begin
      tests_failed++;
      $display("FAIL post_reset_rd: got %h/%b/%b lat %0d want %h/%b/%b lat %0d", obs_rdata, obs_err,
               obs_to, obs_lat, e.rdata, e.err, e.to, e.lat);
    end
    step();
  endtask

  initial begin
    reset_l   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_sizes();
    test_wait_states();
    test_error();
    test_misaligned();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
